// File: rtl/case_5_mul_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : case_5_mul_share_arb_if
// Brief    : Request/response handshake bundle for the shared multiplier.
// Revision : 1.0
// ============================================================================
interface case_5_mul_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DIN0_W  = 11,
    parameter int DIN1_W  = 4,
    parameter int DOUT_W  = 11
);
    localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DIN0_W-1:0] req_din0;
    logic [NUM_REQ*DIN1_W-1:0] req_din1;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DOUT_W-1:0]         rsp_dout;
    logic [c_id_w-1:0]         rsp_id;

    modport slave (
        input  req_valid, req_din0, req_din1, rsp_ready,
        output req_ready, rsp_valid, rsp_dout, rsp_id
    );

    modport master (
        output req_valid, req_din0, req_din1, rsp_ready,
        input  req_ready, rsp_valid, rsp_dout, rsp_id
    );
endinterface
`default_nettype wire

// File: rtl/case_5_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : case_5_mul_share_arb
// Brief    : Round-robin arbiter feeding one pipelined signed multiplier.
// Revision : 1.0
// ============================================================================
module case_5_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_W     = 11,
    parameter int DIN1_W     = 4,
    parameter int DOUT_W     = 11,
    parameter int MUL_STAGES = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    case_5_mul_share_arb_if.slave bus,
    output logic                  busy
);
    localparam int                c_id_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                c_prod_w  = DIN0_W + DIN1_W;
    localparam logic [c_id_w:0]   c_num_req = (c_id_w + 1)'(NUM_REQ);
    localparam logic [c_id_w-1:0] c_last    = c_id_w'(NUM_REQ - 1);
    localparam logic [c_id_w-1:0] c_one     = c_id_w'(1);

    logic                       w_stall;
    logic                       w_found;
    logic                       w_accept;
    logic [c_id_w-1:0]          w_grant;
    logic [c_id_w:0]            w_sum;
    logic [NUM_REQ-1:0]         w_ready;
    logic [c_id_w-1:0]          r_rr_ptr;

    logic signed [DIN0_W-1:0]   w_op0;
    logic signed [DIN1_W-1:0]   w_op1;
    logic signed [c_prod_w-1:0] w_prod_full;
    logic [DOUT_W-1:0]          w_prod;

    logic [MUL_STAGES-1:0]      r_vld;
    logic [DOUT_W-1:0]          r_dout [MUL_STAGES];
    logic [c_id_w-1:0]          r_id   [MUL_STAGES];

    assign w_stall = bus.rsp_valid && !bus.rsp_ready;

    // Rotating priority search starting at r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_id_w + 1)'(k);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            if (!w_found && bus.req_valid[w_sum[c_id_w-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_sum[c_id_w-1:0];
            end
        end
    end

    assign w_ready       = (w_found && !w_stall && ap_rst_n)
                         ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant) : '0;
    assign bus.req_ready = w_ready;
    assign w_accept      = |w_ready;

    assign w_op0       = bus.req_din0[int'(w_grant)*DIN0_W +: DIN0_W];
    assign w_op1       = bus.req_din1[int'(w_grant)*DIN1_W +: DIN1_W];
    assign w_prod_full = c_prod_w'(w_op0) * c_prod_w'(w_op1);

    generate
        if (DOUT_W <= c_prod_w) begin : g_trunc
            assign w_prod = w_prod_full[DOUT_W-1:0];
        end else begin : g_sext
            assign w_prod = DOUT_W'(w_prod_full);
        end
    endgenerate

    // Every stage holds together on stall so ordering and id pairing are kept.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_vld    <= '0;
            r_rr_ptr <= '0;
            for (int s = 0; s < MUL_STAGES; s++) begin
                r_dout[s] <= '0;
                r_id[s]   <= '0;
            end
        end else begin
            if (w_accept) begin
                r_rr_ptr <= (w_grant == c_last) ? '0 : w_grant + c_one;
            end
            if (!w_stall) begin
                r_vld[0]  <= w_accept;
                r_dout[0] <= w_prod;
                r_id[0]   <= w_grant;
                for (int s = 1; s < MUL_STAGES; s++) begin
                    r_vld[s]  <= r_vld[s-1];
                    r_dout[s] <= r_dout[s-1];
                    r_id[s]   <= r_id[s-1];
                end
            end
        end
    end

    assign bus.rsp_valid = r_vld[MUL_STAGES-1];
    assign bus.rsp_dout  = r_dout[MUL_STAGES-1];
    assign bus.rsp_id    = r_id[MUL_STAGES-1];
    assign busy          = |r_vld;
endmodule
`default_nettype wire

// File: tb/tb_case_5_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_case_5_mul_share_arb
// Brief    : Scoreboard bench for the shared multiplier arbiter.
// Revision : 1.0
// ============================================================================
module tb_case_5_mul_share_arb;
    localparam int NUM_REQ    = 4;
    localparam int DIN0_W     = 11;
    localparam int DIN1_W     = 4;
    localparam int DOUT_W     = 11;
    localparam int MUL_STAGES = 2;

    typedef struct {
        int                id;
        logic [DOUT_W-1:0] dout;
        int                acc;
        int                st;
        bit                seen;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;
    logic [NUM_REQ-1:0] last_acc;
    exp_t q[$];

    case_5_mul_share_arb_if #(.NUM_REQ(NUM_REQ), .DIN0_W(DIN0_W), .DIN1_W(DIN1_W),
                              .DOUT_W(DOUT_W)) bus ();

    case_5_mul_share_arb #(.NUM_REQ(NUM_REQ), .DIN0_W(DIN0_W), .DIN1_W(DIN1_W),
                           .DOUT_W(DOUT_W), .MUL_STAGES(MUL_STAGES)) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus.slave),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [DOUT_W-1:0] model_mul(input logic signed [DIN0_W-1:0] a,
                                                     input logic signed [DIN1_W-1:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[DOUT_W-1:0];
    endfunction

    // Reference arbiter: predicts the grant and pushes the expected result.
    initial begin
        int ptr;
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        exp_t e;
        ptr = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                q.delete();
                ptr = 0;
                check("req_ready_in_reset", bus.req_ready, 0);
            end else begin
                g = -1;
                exp_rdy = '0;
                if (!(bus.rsp_valid && !bus.rsp_ready)) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (g < 0 && bus.req_valid[(ptr + k) % NUM_REQ]) g = (ptr + k) % NUM_REQ;
                    end
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
                check("req_ready", bus.req_ready, exp_rdy);
                if (g >= 0) begin
                    e.id   = g;
                    e.dout = model_mul(bus.req_din0[g*DIN0_W +: DIN0_W], bus.req_din1[g*DIN1_W +: DIN1_W]);
                    e.acc  = cyc + 1;
                    e.st   = stall_cnt;
                    e.seen = 1'b0;
                    q.push_back(e);
                    ptr = (g + 1) % NUM_REQ;
                end
            end
        end
    end

    // Monitor: pops and compares whenever a response is presented.
    initial begin
        bit                held;
        logic [DOUT_W-1:0] hd;
        logic [1:0]        hid;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rsp_valid_in_reset", bus.rsp_valid, 0);
                check("busy_in_reset", busy, 0);
                held = 1'b0;
            end else begin
                check("busy", busy, (q.size() != 0));
                if (held && !bus.rsp_valid) begin
                    check("rsp_valid_dropped", bus.rsp_valid, 1);
                    held = 1'b0;
                end
                if (bus.rsp_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_rsp", bus.rsp_valid, 0);
                    end else begin
                        if (!q[0].seen) begin
                            q[0].seen = 1'b1;
                            check("latency", cyc, q[0].acc + MUL_STAGES - 1 + (stall_cnt - q[0].st));
                        end
                        if (held) begin
                            check("stall_dout_stable", bus.rsp_dout, hd);
                            check("stall_id_stable", bus.rsp_id, hid);
                        end
                        if (bus.rsp_ready) begin
                            check("rsp_dout", bus.rsp_dout, q[0].dout);
                            check("rsp_id", bus.rsp_id, q[0].id);
                            void'(q.pop_front());
                            held = 1'b0;
                        end else begin
                            held = 1'b1;
                            hd   = bus.rsp_dout;
                            hid  = bus.rsp_id;
                            stall_cnt++;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        last_acc = bus.req_valid & bus.req_ready;
        @(posedge clk); #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        bus.req_din0[i*DIN0_W +: DIN0_W] = a[DIN0_W-1:0];
        bus.req_din1[i*DIN1_W +: DIN1_W] = b[DIN1_W-1:0];
    endtask

    task automatic send(input int i, input int a, input int b);
        bit got;
        got = 1'b0;
        set_op(i, a, b);
        bus.req_valid[i] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            got = last_acc[i];
        end
        bus.req_valid[i] = 1'b0;
        check("accept_timeout", got, 1);
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, int'($urandom), int'($urandom));
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() != 0; n++) step();
        step();
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_din0  = '0;
        bus.req_din1  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", bus.req_ready, 0);
        check("reset_dout", bus.rsp_dout, 0);
        check("reset_id", bus.rsp_id, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        step();

        send(2, 100, 3);
        repeat (MUL_STAGES + 2) step();
        check("idle_busy", busy, 0);

        send(1, -1024, -8);
        send(0, 1023, 7);
        send(3, -5, 4);
        drain();

        // All requesters valid continuously.
        bus.req_valid = '1;
        for (int n = 0; n < 12; n++) begin
            randomize_ops();
            step();
        end

        // Backpressure with a full pipeline.
        bus.rsp_ready = 1'b0;
        repeat (3) step();
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            randomize_ops();
            step();
        end
        drain();

        // Reset with two entries in flight.
        bus.req_valid = '1;
        randomize_ops();
        repeat (2) step();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("midreset_rsp_valid", bus.rsp_valid, 0);
        check("midreset_busy", busy, 0);
        repeat (2) step();
        rst_n = 1'b1;
        bus.req_valid = 4'b1010;
        step();
        check("post_reset_grant", last_acc, 4'b0010);
        drain();

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            bus.req_valid = NUM_REQ'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            randomize_ops();
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/case_5_mul_share_arb.md
CASE_5_MUL_SHARE_ARB -- requirements
Module: case_5_mul_share_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one multiplier (legal range 2..8).
REQ-002 The block SHALL have parameter DIN0_W, default 11, giving the width of signed operand 0.
REQ-003 The block SHALL have parameter DIN1_W, default 4, giving the width of signed operand 1.
REQ-004 The block SHALL have parameter DOUT_W, default 11, giving the width of the signed result.
REQ-005 The block SHALL have parameter MUL_STAGES, default 1, giving the number of multiplier pipeline registers (legal range 1..4).
REQ-006 The block SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept.
REQ-010 The block SHALL have port req_din0, input, NUM_REQ*DIN0_W bits: operand 0, requester i in slice [i*DIN0_W +: DIN0_W].
REQ-011 The block SHALL have port req_din1, input, NUM_REQ*DIN1_W bits: operand 1, packed the same way.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: result valid.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: result consumer accept.
REQ-014 The block SHALL have port rsp_dout, output, DOUT_W bits: result.
REQ-015 The block SHALL have port rsp_id, output, clog2(NUM_REQ) bits: index of the requester owning rsp_dout.
REQ-016 The block SHALL have port busy, output, 1 bit: high when any pipeline stage holds a valid entry.

Function
REQ-017 Transfers SHALL occur on req_valid[i]&&req_ready[i] and on rsp_valid&&rsp_ready; at most one request SHALL be accepted per cycle.
REQ-018 stall SHALL be defined as rsp_valid && !rsp_ready; while stall is high, all pipeline stages SHALL hold and req_ready SHALL be all-zero.
REQ-019 When not stalled, grant SHALL go to the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ; req_ready SHALL be one-hot of that grant, combinational from req_valid, rr_ptr and stall.
REQ-020 On an accepted grant g, rr_ptr SHALL become (g+1) mod NUM_REQ; otherwise rr_ptr SHALL hold. Wrap from NUM_REQ-1 SHALL return to 0.
REQ-021 req_ready SHALL NOT depend on req_din0/req_din1; a requester SHALL be allowed to drop req_valid without a transfer.
REQ-022 The product SHALL be signed(din0)*signed(din1) computed at full DIN0_W+DIN1_W width, then truncated to the low DOUT_W bits (two's-complement wrap, no saturation).
REQ-023 A request accepted at edge t SHALL appear on rsp_valid/rsp_dout/rsp_id after edge t+MUL_STAGES-1 (visible MUL_STAGES cycles later) when no stall intervenes; each stall cycle SHALL add exactly one cycle.
REQ-024 Results SHALL leave in acceptance order; rsp_id SHALL travel with its operands through every stage.
REQ-025 Without stalls, throughput SHALL be one result per cycle; an accept and a response SHALL be allowed in the same cycle.
REQ-026 rsp_dout and rsp_id SHALL remain stable while rsp_valid&&!rsp_ready.
REQ-027 busy SHALL equal the OR of all stage valid bits.

Reset
REQ-028 On ap_rst_n low, all stage valid bits, rsp_valid, busy and rr_ptr SHALL clear to 0 immediately, and rsp_dout and rsp_id SHALL read 0.
REQ-029 While ap_rst_n is low, req_ready SHALL be all-zero; in-flight operations SHALL be discarded, not completed.
REQ-030 The first grant after reset release SHALL search from index 0.

Verification
REQ-031 Single request: req 2 sends din0=100, din1=3, rsp_ready=1 -> rsp_dout=300, rsp_id=2 after MUL_STAGES cycles; busy then 0.
REQ-032 Wrap/sign: din0=-1024, din1=-8 -> 0; din0=1023, din1=7 -> 1017; din0=-5, din1=4 -> -20.
REQ-033 Round-robin: all 4 requesters valid continuously -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence matches.
REQ-034 Backpressure: rsp_ready held 0 for 3 cycles with a full pipeline -> req_ready=0000, rsp_dout/rsp_id stable, no loss or duplication after release.
REQ-035 Reset mid-operation: ap_rst_n pulsed low with 2 entries in flight -> rsp_valid=0, busy=0 at once; no stale result after release; next grant from index 0.
